param_updown_counter: RTL and testbench

- Parametrised synchronous up/down counter; generational successor to the team's fixed 3-bit T-flip-flop up/down counter.
- Adds configurable width, runtime modulus, parallel load and count enable.
- Three boundary modes: wrap, saturate, ping-pong.
- Used as a general event/position counter and timebase in datapath and control blocks.

---
 rtl/param_updown_counter_pkg.sv | 8 +
 rtl/param_updown_counter_if.sv | 14 +
 rtl/param_updown_counter_next_val.sv | 29 ++
 rtl/param_updown_counter.sv | 67 ++++++
 tb/tb_param_updown_counter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/param_updown_counter_pkg.sv
// param_updown_counter_pkg: mode and direction encodings shared by the counter, its interface users and benches
package param_updown_counter_pkg;
  localparam logic [1:0] MODE_WRAP     = 2'd0;
  localparam logic [1:0] MODE_SAT      = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/param_updown_counter_if.sv
// param_updown_counter_if: control and status bundle of the up/down counter; master drives, slave is the counter
interface param_updown_counter_if #(parameter int WIDTH = 3) ();
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] count;
  logic             dir_out;
  logic             tc;
  modport master (output en, dir, mode, load, load_val, max_val, input count, dir_out, tc);
  modport slave  (input en, dir, mode, load, load_val, max_val, output count, dir_out, tc);
endinterface

// File: rtl/param_updown_counter_next_val.sv
// counter_next_val: next count, bound detection and ping-pong reversal for one step of the counter
module counter_next_val
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic             dir_eff,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt,
  output logic             at_bound,
  output logic             flip_dir
);
  logic             down;
  logic             zmax;
  logic [WIDTH-1:0] bound_val;
  // a count above max_val counts as top; reserved mode 3 falls through to wrap
  always_comb begin
    down      = dir_eff == DIR_DOWN;
    zmax      = max_val == '0;
    at_bound  = down ? count == '0 : count >= max_val;
    flip_dir  = at_bound && mode == MODE_PINGPONG && !zmax;
    bound_val = mode == MODE_SAT      ? (down ? '0 : max_val) :
                mode == MODE_PINGPONG ? (zmax ? '0 : down ? WIDTH'(1) : max_val - WIDTH'(1)) :
                                        (down ? max_val : '0);
    nxt       = at_bound ? bound_val : down ? count - WIDTH'(1) : count + WIDTH'(1);
  end
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: wrap/saturate/ping-pong up/down counter with load; PARAM_UPDOWN_COUNTER_PRESCALE_EN adds an enable prescaler
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 4
) (
  input logic clk,
  input logic reset,
  param_updown_counter_if.slave bus
);
  if (WIDTH < 1 || PRESCALE < 1) begin : g_bad_param
    $error("param_updown_counter: WIDTH and PRESCALE must be >= 1");
  end
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             dir_q;
  logic             tc_q;
  logic             dir_eff;
  logic             at_bound;
  logic             flip_dir;
  logic             step_en;
`ifdef PARAM_UPDOWN_COUNTER_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q;
  assign step_en = bus.en && pre_q == PW'(PRESCALE - 1);
  // prescaler advances only on enabled cycles and restarts its window on reset and load
  always_ff @(posedge clk)
    if (!reset || bus.load) pre_q <= '0;
    else if (bus.en) pre_q <= step_en ? '0 : pre_q + PW'(1);
`else
  assign step_en = bus.en;
`endif
  assign dir_eff      = bus.mode == MODE_PINGPONG ? dir_q : bus.dir;
  assign load_clamped = bus.load_val > bus.max_val ? bus.max_val : bus.load_val;
  counter_next_val #(.WIDTH(WIDTH)) u_next (
    .count   (count_q),
    .max_val (bus.max_val),
    .dir_eff (dir_eff),
    .mode    (bus.mode),
    .nxt     (nxt),
    .at_bound(at_bound),
    .flip_dir(flip_dir)
  );
  // reset beats load beats step; tc marks a step taken at a bound and clears otherwise
  always_ff @(posedge clk)
    if (!reset) begin
      count_q <= WIDTH'(RESET_VAL);
      tc_q    <= 1'b0;
      dir_q   <= DIR_UP;
    end else if (bus.load) begin
      count_q <= load_clamped;
      tc_q    <= 1'b0;
      dir_q   <= bus.dir;
    end else if (step_en) begin
      count_q <= nxt;
      tc_q    <= at_bound;
      dir_q   <= dir_q ^ flip_dir;
    end else begin
      tc_q    <= 1'b0;
    end
  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.dir_out = dir_eff;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed checks of a WIDTH=3 and a WIDTH=4 (RESET_VAL=2) counter
module tb_param_updown_counter;
  import param_updown_counter_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  param_updown_counter_if #(.WIDTH(3)) b3();
  param_updown_counter_if #(.WIDTH(4)) b4();
  param_updown_counter #(.WIDTH(3)) d3 (.clk(clk), .reset(reset), .bus(b3));
  param_updown_counter #(.WIDTH(4), .RESET_VAL(2)) d4 (.clk(clk), .reset(reset), .bus(b4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b3.en = 0; b3.dir = DIR_UP; b3.mode = MODE_WRAP; b3.load = 0; b3.load_val = 0; b3.max_val = 3'd7;
    b4.en = 0; b4.dir = DIR_UP; b4.mode = MODE_WRAP; b4.load = 0; b4.load_val = 0; b4.max_val = 4'd15;
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    tick();
    tick();
    n_cmp++; if (b3.count !== 3'd0) begin n_bad++; $display("FAIL reset_count3 got %0d want 0", b3.count); end
    n_cmp++; if (b3.tc !== 1'b0) begin n_bad++; $display("FAIL reset_tc3 got %b want 0", b3.tc); end
    n_cmp++; if (b3.dir_out !== 1'b0) begin n_bad++; $display("FAIL reset_dir3 got %b want 0", b3.dir_out); end
    n_cmp++; if (b4.count !== 4'd2) begin n_bad++; $display("FAIL reset_count4 got %0d want 2", b4.count); end
    reset = 1;
  endtask

  task automatic test_wrap();
    idle();
    do_reset();
    b3.en = 1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_cmp++; if (b3.count !== 3'(i % 8)) begin n_bad++; $display("FAIL wrap_count step %0d got %0d want %0d", i, b3.count, i % 8); end
      n_cmp++; if (b3.tc !== (i == 8)) begin n_bad++; $display("FAIL wrap_tc step %0d got %b want %b", i, b3.tc, i == 8); end
    end
    b3.en = 0;
  endtask

  task automatic test_saturate();
    int ec[4] = '{1, 0, 0, 0};
    logic et[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    idle();
    b4.mode = MODE_SAT; b4.dir = DIR_DOWN; b4.max_val = 4'd5; b4.load_val = 4'd2; b4.load = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd2) begin n_bad++; $display("FAIL sat_load got %0d want 2", b4.count); end
    b4.load = 0; b4.en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (b4.count !== 4'(ec[i])) begin n_bad++; $display("FAIL sat_count step %0d got %0d want %0d", i + 1, b4.count, ec[i]); end
      n_cmp++; if (b4.tc !== et[i]) begin n_bad++; $display("FAIL sat_tc step %0d got %b want %b", i + 1, b4.tc, et[i]); end
    end
    b4.en = 0;
    tick();
    n_cmp++; if (b4.tc !== 1'b0) begin n_bad++; $display("FAIL sat_tc_idle got %b want 0", b4.tc); end
    n_cmp++; if (b4.count !== 4'd0) begin n_bad++; $display("FAIL sat_hold got %0d want 0", b4.count); end
  endtask

  task automatic test_pingpong();
    int ec[7] = '{1, 2, 3, 2, 1, 0, 1};
    logic et[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic ed[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    idle();
    do_reset();
    b3.mode = MODE_PINGPONG; b3.max_val = 3'd3; b3.dir = DIR_DOWN; b3.en = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (b3.count !== 3'(ec[i])) begin n_bad++; $display("FAIL pp_count step %0d got %0d want %0d", i + 1, b3.count, ec[i]); end
      n_cmp++; if (b3.tc !== et[i]) begin n_bad++; $display("FAIL pp_tc step %0d got %b want %b", i + 1, b3.tc, et[i]); end
      n_cmp++; if (b3.dir_out !== ed[i]) begin n_bad++; $display("FAIL pp_dir step %0d got %b want %b", i + 1, b3.dir_out, ed[i]); end
    end
    b3.en = 0;
  endtask

  task automatic test_load();
    idle();
    b4.max_val = 4'd6; b4.load_val = 4'd9; b4.en = 1; b4.load = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd6) begin n_bad++; $display("FAIL load_clamp got %0d want 6", b4.count); end
    n_cmp++; if (b4.tc !== 1'b0) begin n_bad++; $display("FAIL load_tc got %b want 0", b4.tc); end
    reset = 0;
    tick();
    n_cmp++; if (b4.count !== 4'd2) begin n_bad++; $display("FAIL load_vs_reset got %0d want 2", b4.count); end
    reset = 1;
    b4.mode = MODE_PINGPONG; b4.dir = DIR_DOWN; b4.load_val = 4'd3; b4.en = 0;
    tick();
    n_cmp++; if (b4.count !== 4'd3) begin n_bad++; $display("FAIL load_pp got %0d want 3", b4.count); end
    n_cmp++; if (b4.dir_out !== 1'b1) begin n_bad++; $display("FAIL load_pp_dir got %b want 1", b4.dir_out); end
`ifndef PARAM_UPDOWN_COUNTER_PRESCALE_EN
    b4.load = 0; b4.dir = DIR_UP; b4.en = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd2) begin n_bad++; $display("FAIL load_pp_step got %0d want 2", b4.count); end
`endif
    b4.load = 0; b4.en = 0;
  endtask

  task automatic test_max_change();
    idle();
    b4.max_val = 4'd7; b4.load_val = 4'd6; b4.load = 1;
    tick();
    b4.load = 0; b4.max_val = 4'd4; b4.en = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd0) begin n_bad++; $display("FAIL maxdrop_up got %0d want 0", b4.count); end
    n_cmp++; if (b4.tc !== 1'b1) begin n_bad++; $display("FAIL maxdrop_up_tc got %b want 1", b4.tc); end
    b4.en = 0; b4.max_val = 4'd7; b4.load = 1;
    tick();
    b4.load = 0; b4.max_val = 4'd4; b4.dir = DIR_DOWN; b4.en = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd5) begin n_bad++; $display("FAIL maxdrop_down got %0d want 5", b4.count); end
    n_cmp++; if (b4.tc !== 1'b0) begin n_bad++; $display("FAIL maxdrop_down_tc got %b want 0", b4.tc); end
    b4.en = 0;
  endtask

  task automatic test_max_zero();
    idle();
    b4.max_val = 4'd0; b4.mode = MODE_SAT; b4.load_val = 4'd5; b4.load = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd0) begin n_bad++; $display("FAIL zero_load got %0d want 0", b4.count); end
    b4.load = 0; b4.en = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (b4.count !== 4'd0 || b4.tc !== 1'b1) begin n_bad++; $display("FAIL zero_sat step %0d got count %0d tc %b want 0/1", i, b4.count, b4.tc); end
    end
    b4.mode = MODE_PINGPONG;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (b4.count !== 4'd0 || b4.tc !== 1'b1 || b4.dir_out !== 1'b0) begin n_bad++; $display("FAIL zero_pp step %0d got count %0d tc %b dir %b want 0/1/0", i, b4.count, b4.tc, b4.dir_out); end
    end
    b4.en = 0;
  endtask

  task automatic test_reserved();
    idle();
    b4.mode = 2'd3; b4.max_val = 4'd3; b4.load_val = 4'd3; b4.load = 1;
    tick();
    b4.load = 0; b4.en = 1;
    tick();
    n_cmp++; if (b4.count !== 4'd0 || b4.tc !== 1'b1) begin n_bad++; $display("FAIL reserved_wrap got count %0d tc %b want 0/1", b4.count, b4.tc); end
    b4.en = 0;
  endtask

  task automatic test_prescale();
    idle();
    do_reset();
    b3.en = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_cmp++; if (b3.count !== 3'(i / 4)) begin n_bad++; $display("FAIL pre_count cycle %0d got %0d want %0d", i, b3.count, i / 4); end
    end
    tick();
    tick();
    b3.en = 0;
    tick();
    tick();
    b3.en = 1;
    tick();
    n_cmp++; if (b3.count !== 3'd3) begin n_bad++; $display("FAIL pre_hold got %0d want 3", b3.count); end
    tick();
    n_cmp++; if (b3.count !== 3'd4) begin n_bad++; $display("FAIL pre_resume got %0d want 4", b3.count); end
    b3.en = 0;
  endtask

  initial begin
    test_reset();
`ifdef PARAM_UPDOWN_COUNTER_PRESCALE_EN
    test_load();
    test_prescale();
`else
    test_wrap();
    test_saturate();
    test_pingpong();
    test_load();
    test_max_change();
    test_max_zero();
    test_reserved();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
